// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-style memory port between the instruction
// fetch requester and the load/store requester of a pipelined core. Accesses
// are serialised, the pipeline is stalled while a request is outstanding, read
// data returns with a one-cycle done pulse, and a hung memory is aborted after
// a programmable number of cycles.
//
// Ports:
//   clka, rst                 clock (rising edge), async active-high reset
//   inst_req/addr             fetch request (level, held until inst_done)
//   inst_rdata/done           fetched word and one-cycle completion pulse
//   data_req/wr/addr/wmask/wdata  load/store request (held until data_done)
//   data_rdata/done           load data and one-cycle completion pulse
//   mem_req/wr/addr/wmask/wdata   memory request, held until mem_ack
//   mem_ack/rdata             single-cycle memory completion and read data
//   stall                     combinational pipeline stall
//   timeout_err               sticky flag, set when an access was aborted
module mem_port_arbiter #(
   parameter int unsigned MAX_DATA_RUN = 4,
   parameter int unsigned TIMEOUT      = 64,
   parameter logic [31:0] ABORT_DATA   = 32'h0000_0000
) (
   input  logic        clka,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_done,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [31:0] data_addr,
   input  logic [3:0]  data_wmask,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_done,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wmask,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic        timeout_err
);

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned MW    = 4;
   localparam int unsigned RUN_W = 4;
   localparam int unsigned TO_W  = 8;

   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);
   localparam bit               TO_EN   = (TIMEOUT != 0);
   // Abort fires in the TIMEOUT-th cycle of the grant that sees no ack.
   localparam logic [TO_W-1:0]  TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [TO_W-1:0]  tcnt_q, tcnt_d;

   logic          mem_req_d, mem_wr_d;
   logic [AW-1:0] mem_addr_d;
   logic [MW-1:0] mem_wmask_d;
   logic [DW-1:0] mem_wdata_d;
   logic          inst_done_d, data_done_d;
   logic [DW-1:0] inst_rdata_d, data_rdata_d;
   logic          timeout_err_d;

   logic inst_elig, data_elig, idle_open, force_inst;
   logic pick_data, pick_inst, abort;

   // A requester still high during its own done cycle is not re-issued.
   assign inst_elig  = inst_req & ~inst_done;
   assign data_elig  = data_req & ~data_done;
   // The completion cycle is a dead IDLE cycle: nothing is granted in it.
   assign idle_open  = ~inst_done & ~data_done;
   assign force_inst = (run_q >= RUN_MAX) & inst_elig;
   assign pick_data  = idle_open & data_elig & ~force_inst;
   assign pick_inst  = idle_open & inst_elig & ~pick_data;
   // An ack in the same cycle as the limit wins over the abort.
   assign abort      = TO_EN & ~mem_ack & (tcnt_q == TO_LAST);

   assign stall = (inst_req & ~inst_done) | (data_req & ~data_done);

   // State register.
   always_ff @(posedge clka or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pick_data)      state_d = GNT_D;
            else if (pick_inst) state_d = GNT_I;
         end
         GNT_I, GNT_D: begin
            if (mem_ack || abort) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs and counters.
   always_comb begin
      mem_req_d     = mem_req;
      mem_wr_d      = mem_wr;
      mem_addr_d    = mem_addr;
      mem_wmask_d   = mem_wmask;
      mem_wdata_d   = mem_wdata;
      inst_done_d   = 1'b0;
      data_done_d   = 1'b0;
      inst_rdata_d  = inst_rdata;
      data_rdata_d  = data_rdata;
      timeout_err_d = timeout_err;
      run_d         = run_q;
      tcnt_d        = tcnt_q;
      case (state_q)
         IDLE: begin
            if (pick_data) begin
               mem_req_d   = 1'b1;
               mem_wr_d    = data_wr;
               mem_addr_d  = data_addr;
               mem_wmask_d = data_wr ? data_wmask : '0;
               mem_wdata_d = data_wdata;
               tcnt_d      = '0;
               // Only data grants that bypass a waiting fetch count toward the run.
               if (inst_elig && run_q != '1) run_d = run_q + RUN_W'(1);
            end else if (pick_inst) begin
               mem_req_d   = 1'b1;
               mem_wr_d    = 1'b0;
               mem_addr_d  = inst_addr;
               mem_wmask_d = '0;
               mem_wdata_d = '0;
               tcnt_d      = '0;
               run_d       = '0;
            end
         end
         GNT_I, GNT_D: begin
            if (mem_ack || abort) begin
               mem_req_d = 1'b0;
               if (state_q == GNT_I) begin
                  inst_done_d  = 1'b1;
                  inst_rdata_d = mem_ack ? mem_rdata : ABORT_DATA;
               end else begin
                  data_done_d  = 1'b1;
                  data_rdata_d = mem_ack ? mem_rdata : ABORT_DATA;
               end
               if (!mem_ack) timeout_err_d = 1'b1;
            end else if (tcnt_q != '1) begin
               tcnt_d = tcnt_q + TO_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Output and counter registers.
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         mem_req     <= 1'b0;
         mem_wr      <= 1'b0;
         mem_addr    <= '0;
         mem_wmask   <= '0;
         mem_wdata   <= '0;
         inst_done   <= 1'b0;
         data_done   <= 1'b0;
         inst_rdata  <= '0;
         data_rdata  <= '0;
         timeout_err <= 1'b0;
         run_q       <= '0;
         tcnt_q      <= '0;
      end else begin
         mem_req     <= mem_req_d;
         mem_wr      <= mem_wr_d;
         mem_addr    <= mem_addr_d;
         mem_wmask   <= mem_wmask_d;
         mem_wdata   <= mem_wdata_d;
         inst_done   <= inst_done_d;
         data_done   <= data_done_d;
         inst_rdata  <= inst_rdata_d;
         data_rdata  <= data_rdata_d;
         timeout_err <= timeout_err_d;
         run_q       <= run_d;
         tcnt_q      <= tcnt_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a simple
// memory responder (configurable ack delay, or no ack at all).
module tb_mem_port_arbiter;

   logic        clka;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_done;
   logic        data_req;
   logic        data_wr;
   logic [31:0] data_addr;
   logic [3:0]  data_wmask;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_done;
   logic        mem_req;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        stall;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;

   // responder controls
   bit          manual;
   bit          ack_en;
   int          ack_delay;
   logic [31:0] resp_data;
   int          wait_cnt;

   // grant log
   bit   glog[$];
   int   gcyc[$];
   int   cyc_cnt = 0;
   logic req_q = 1'b0;

   mem_port_arbiter #(
      .MAX_DATA_RUN(4),
      .TIMEOUT(8),
      .ABORT_DATA(32'h0000_0000)
   ) dut (
      .clka(clka),
      .rst(rst),
      .inst_req(inst_req),
      .inst_addr(inst_addr),
      .inst_rdata(inst_rdata),
      .inst_done(inst_done),
      .data_req(data_req),
      .data_wr(data_wr),
      .data_addr(data_addr),
      .data_wmask(data_wmask),
      .data_wdata(data_wdata),
      .data_rdata(data_rdata),
      .data_done(data_done),
      .mem_req(mem_req),
      .mem_wr(mem_wr),
      .mem_addr(mem_addr),
      .mem_wmask(mem_wmask),
      .mem_wdata(mem_wdata),
      .mem_ack(mem_ack),
      .mem_rdata(mem_rdata),
      .stall(stall),
      .timeout_err(timeout_err)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   always @(posedge clka) cyc_cnt++;

   // Memory model: acks ack_delay cycles after mem_req is first seen high.
   always begin
      @(posedge clka);
      #2;
      if (!manual) begin
         if (rst || !ack_en || !mem_req) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
         end else if (wait_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = resp_data;
            wait_cnt  = 0;
         end else begin
            mem_ack = 1'b0;
            wait_cnt++;
         end
      end
   end

   // Log each new grant: 1 = instruction (addr 0x1000), 0 = data.
   always @(negedge clka) begin
      if (mem_req && !req_q) begin
         glog.push_back(mem_addr == 32'h0000_1000);
         gcyc.push_back(cyc_cnt);
      end
      req_q = mem_req;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge (input drive point).
   task automatic cyc();
      @(posedge clka);
      #1;
   endtask

   task automatic wait_done(input string tag, input bit is_data, input int max_cyc, output int n);
      n = 0;
      do begin
         @(negedge clka);
         n++;
      end while (!(is_data ? data_done : inst_done) && n < max_cyc);
      chk({tag, "_done"}, 32'(is_data ? data_done : inst_done), 32'd1);
   endtask

   task automatic run_until_data_done(input int max_cyc, output int hi, output int n);
      hi = 0;
      n  = 0;
      do begin
         @(negedge clka);
         n++;
         if (mem_req) hi++;
      end while (!data_done && n < max_cyc);
   endtask

   bit exp_is_i [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      int n;
      int hi;
      rst = 1'b1;
      inst_req = 1'b0; inst_addr = '0;
      data_req = 1'b0; data_wr = 1'b0; data_addr = '0; data_wmask = '0; data_wdata = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      manual = 1'b0; ack_en = 1'b1; ack_delay = 0; resp_data = '0; wait_cnt = 0;

      repeat (2) @(posedge clka);
      @(negedge clka);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_inst_done", 32'(inst_done), 32'd0);
      chk("rst_data_done", 32'(data_done), 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_data_rdata", data_rdata, 32'd0);
      cyc();
      rst = 1'b0;
      cyc();

      // Single fetch, ack one cycle after mem_req
      ack_delay = 1; resp_data = 32'h2402_0005;
      inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
      @(negedge clka);
      chk("f_c0_stall", 32'(stall), 32'd1);
      chk("f_c0_mem_req", 32'(mem_req), 32'd0);
      cyc(); @(negedge clka);
      chk("f_c1_mem_req", 32'(mem_req), 32'd1);
      chk("f_c1_addr", mem_addr, 32'hBFC0_0000);
      chk("f_c1_wr", 32'(mem_wr), 32'd0);
      chk("f_c1_wmask", 32'(mem_wmask), 32'd0);
      chk("f_c1_stall", 32'(stall), 32'd1);
      cyc(); @(negedge clka);
      chk("f_c2_done", 32'(inst_done), 32'd0);
      chk("f_c2_stall", 32'(stall), 32'd1);
      cyc(); @(negedge clka);
      chk("f_c3_done", 32'(inst_done), 32'd1);
      chk("f_c3_rdata", inst_rdata, 32'h2402_0005);
      chk("f_c3_mem_req", 32'(mem_req), 32'd0);
      chk("f_c3_stall", 32'(stall), 32'd0);
      cyc();
      inst_req = 1'b0;
      @(negedge clka);
      chk("f_c4_done", 32'(inst_done), 32'd0);
      chk("f_c4_rdata_hold", inst_rdata, 32'h2402_0005);

      // Store then load to 0x80, immediate acks
      cyc();
      ack_delay = 0; resp_data = 32'hFFFF_FFFF;
      data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h80; data_wmask = 4'b0011; data_wdata = 32'h1234_ABCD;
      cyc(); @(negedge clka);
      chk("st_mem_req", 32'(mem_req), 32'd1);
      chk("st_wr", 32'(mem_wr), 32'd1);
      chk("st_addr", mem_addr, 32'h80);
      chk("st_wmask", 32'(mem_wmask), 32'b0011);
      chk("st_wdata", mem_wdata, 32'h1234_ABCD);
      cyc(); @(negedge clka);
      chk("st_done", 32'(data_done), 32'd1);
      cyc();
      data_wr = 1'b0; data_wmask = 4'hF; data_wdata = 32'h5555_5555; resp_data = 32'h0000_ABCD;
      @(negedge clka);
      chk("ld_c0_done", 32'(data_done), 32'd0);
      cyc(); @(negedge clka);
      chk("ld_wr", 32'(mem_wr), 32'd0);
      chk("ld_wmask", 32'(mem_wmask), 32'd0);
      chk("ld_addr", mem_addr, 32'h80);
      cyc(); @(negedge clka);
      chk("ld_done", 32'(data_done), 32'd1);
      chk("ld_rdata", data_rdata, 32'h0000_ABCD);
      cyc();
      data_req = 1'b0;
      cyc();

      // Priority / fairness: both requesters held continuously
      glog.delete(); gcyc.delete();
      resp_data = 32'h0;
      inst_req = 1'b1; inst_addr = 32'h0000_1000;
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_2000; data_wmask = '0;
      n = 0;
      while (glog.size() < 10 && n < 60) begin
         @(negedge clka);
         n++;
      end
      chk("prio_grants", 32'(glog.size()), 32'd10);
      cyc();
      inst_req = 1'b0; data_req = 1'b0;
      for (int i = 0; i < glog.size() && i < 10; i++)
         chk($sformatf("prio_order%0d", i), 32'(glog[i]), 32'(exp_is_i[i]));
      for (int i = 1; i < gcyc.size(); i++)
         chk($sformatf("prio_gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd3);
      repeat (3) cyc();

      // Ack in the same cycle the timeout limit is reached
      ack_delay = 7; resp_data = 32'hCAFE_0001;
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h40;
      run_until_data_done(20, hi, n);
      chk("tie_req_cycles", 32'(hi), 32'd8);
      chk("tie_done", 32'(data_done), 32'd1);
      chk("tie_latency", 32'(n), 32'd10);
      chk("tie_rdata", data_rdata, 32'hCAFE_0001);
      chk("tie_err", 32'(timeout_err), 32'd0);
      cyc();
      data_req = 1'b0;
      cyc();

      // Timeout: never ack a load
      ack_en = 1'b0;
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h44;
      run_until_data_done(20, hi, n);
      chk("to_req_cycles", 32'(hi), 32'd8);
      chk("to_done", 32'(data_done), 32'd1);
      chk("to_latency", 32'(n), 32'd10);
      chk("to_rdata", data_rdata, 32'h0);
      chk("to_err", 32'(timeout_err), 32'd1);
      cyc();
      data_req = 1'b0;
      cyc();
      ack_en = 1'b1; ack_delay = 0; resp_data = 32'h0000_0055;
      data_req = 1'b1; data_addr = 32'h50;
      wait_done("to_next", 1'b1, 8, n);
      chk("to_next_rdata", data_rdata, 32'h0000_0055);
      chk("to_err_sticky", 32'(timeout_err), 32'd1);
      cyc();
      data_req = 1'b0;
      cyc();

      // Async reset while granted, then a late ack in IDLE
      ack_en = 1'b0;
      data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h44;
      cyc(); @(negedge clka);
      chk("ar_mem_req_before", 32'(mem_req), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_mem_req", 32'(mem_req), 32'd0);
      chk("ar_data_done", 32'(data_done), 32'd0);
      chk("ar_err", 32'(timeout_err), 32'd0);
      chk("ar_data_rdata", data_rdata, 32'd0);
      chk("ar_stall", 32'(stall), 32'd1);
      cyc();
      data_req = 1'b0;
      cyc();
      rst = 1'b0;
      manual = 1'b1;
      cyc();
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      cyc();
      mem_ack = 1'b0;
      @(negedge clka);
      chk("late_ack_data_done", 32'(data_done), 32'd0);
      chk("late_ack_inst_done", 32'(inst_done), 32'd0);
      chk("late_ack_mem_req", 32'(mem_req), 32'd0);
      chk("late_ack_rdata", data_rdata, 32'd0);
      manual = 1'b0;
      cyc();
      ack_en = 1'b1; ack_delay = 0; resp_data = 32'h0000_0077;
      data_req = 1'b1; data_addr = 32'h48;
      wait_done("ar_after", 1'b1, 8, n);
      chk("ar_after_latency", 32'(n), 32'd3);
      chk("ar_after_rdata", data_rdata, 32'h0000_0077);
      chk("ar_after_addr", mem_addr, 32'h48);
      cyc();
      data_req = 1'b0;
      repeat (2) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one SRAM-style memory port between the instruction-fetch requester and the load/store requester of the pipelined MIPS core.
- Sits between the core's fetch/MEM stages and the unified memory.
- Serialises accesses, holds the pipeline stall, returns read data with a one-cycle done pulse, and guards against a hung memory with a timeout.

Parameters:
- MAX_DATA_RUN, 4: consecutive data grants allowed while an instruction request is pending, before instruction is forced; range 1..15.
- TIMEOUT, 64: cycles mem_req may stay high without mem_ack before abort; 0 disables; max 255.
- ABORT_DATA, 32'h0000_0000: rdata returned on an aborted access.

Ports:
- clka  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- inst_req  in  1  fetch request, level, held until inst_done
- inst_addr  in  32  fetch byte address
- inst_rdata  out  32  fetched word, valid while inst_done=1
- inst_done  out  1  one-cycle completion pulse
- data_req  in  1  load/store request, level, held until data_done
- data_wr  in  1  1=store, 0=load
- data_addr  in  32  data byte address
- data_wmask  in  4  byte write mask (store only)
- data_wdata  in  32  store data
- data_rdata  out  32  load data, valid while data_done=1
- data_done  out  1  one-cycle completion pulse
- mem_req  out  1  memory request, held until mem_ack
- mem_wr  out  1  write strobe
- mem_addr  out  32  memory address
- mem_wmask  out  4  byte mask; 4'b0000 on reads
- mem_wdata  out  32  write data
- mem_ack  in  1  memory completion, single-cycle; mem_rdata valid same cycle
- mem_rdata  in  32  memory read data
- stall  out  1  combinational: (inst_req & ~inst_done) | (data_req & ~data_done)
- timeout_err  out  1  sticky abort flag

Behaviour:
- Reset (async, immediate):
  - FSM=IDLE; run counter and timeout counter = 0.
  - All registered outputs = 0: mem_req, mem_wr, mem_addr, mem_wmask, mem_wdata, inst_done, inst_rdata, data_done, data_rdata, timeout_err.
  - Reset mid-access drops mem_req with no done pulse; any later mem_ack is ignored in IDLE.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE:
  - Eligible requester: req=1 and its done=0 in the current cycle. This stops a request still high during its own done cycle from being re-issued.
  - Selection: data wins, unless run counter >= MAX_DATA_RUN and inst is eligible; then inst wins.
  - On grant: register mem_addr/mem_wr/mem_wmask/mem_wdata from the winner. Instruction grant uses mem_wr=0, mask 0. A data load uses mask 0.
  - Set mem_req=1 on the next edge and enter GNT_x.
- Run counter:
  - Increments (saturating at 15) on a data grant while inst is eligible.
  - Clears on an instruction grant.
  - Unchanged otherwise.
- GNT_x:
  - mem_* held stable; requester inputs ignored.
  - On mem_ack: next edge clears mem_req, pulses x_done=1 for one cycle, captures x_rdata=mem_rdata (stores capture too, content don't-care), returns to IDLE.
- Latency:
  - Request seen in cycle 0, mem_req high in cycle 1.
  - Ack in cycle k (k>=1) gives done in cycle k+1.
  - Minimum 2 cycles; back-to-back throughput is one access per 3 cycles (done cycle is IDLE).
- x_rdata holds its value until the next completion of the same requester.
- Timeout (TIMEOUT>0):
  - Counter clears on grant and increments each cycle in GNT_x without mem_ack.
  - When the count reaches TIMEOUT with no ack, the next edge drops mem_req, pulses x_done, sets x_rdata=ABORT_DATA, sets timeout_err=1 (sticky until rst), and returns to IDLE.
  - mem_ack in the same cycle as the count reaching TIMEOUT: the ack wins and the access completes normally.
- Requester changing addr/data while granted has no effect. Dropping req while granted has no effect; the access still completes and done still pulses.
- Simultaneous inst_req and data_req rise in IDLE: data granted, counter becomes 1.

Test Plan:
- Single fetch: inst_req=1, inst_addr=0xBFC00000; memory acks one cycle after mem_req with 0x24020005 -> mem_addr=0xBFC00000, mem_wr=0, inst_done pulse at cycle 3 with inst_rdata=0x24020005; stall high cycles 0-2.
- Store then load: data store addr 0x80, mask 4'b0011, wdata 0x1234ABCD; then load 0x80 returning 0x0000ABCD -> mem_wmask 0011 then 0000, two data_done pulses, data_rdata=0x0000ABCD.
- Priority/fairness: data_req and inst_req held continuously, MAX_DATA_RUN=4, immediate acks -> grant order D,D,D,D,I,D,D,D,D,I; no grant in a requester's done cycle.
- Timeout: TIMEOUT=8, never ack a load -> mem_req high exactly 8 cycles, data_done pulse with data_rdata=0, timeout_err=1 and remains 1 across later normal accesses.
- Ack/timeout tie: mem_ack on cycle 8 of TIMEOUT=8 -> normal completion, rdata=mem_rdata, timeout_err stays 0.
- Async reset mid-access: assert rst between clock edges while in GNT_D -> mem_req, done, stall-related registers 0 immediately; late mem_ack ignored; first request after release granted normally.
